// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter with grant timeout and optional bus parking.
// Parking on the last owner is enabled by defining PCI_ARB_PARK_EN.
module pci_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int GNT_TIMEOUT = 16,
  parameter int IDX_W       = 2
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [NUM_MASTERS-1:0] REQ_n,
  input  logic                   FRAME,
  input  logic                   IRDY,
  output logic [NUM_MASTERS-1:0] GNT_n,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   bus_busy,
  output logic                   timeout_o
);

  localparam int TW = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(GNT_TIMEOUT - 1);
  localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [TW-1:0]          tmo_cnt;
  logic [IDX_W-1:0]       sel;
  logic                   any_req;
  logic                   other_req;
  logic                   idle;
  logic [NUM_MASTERS-1:0] sel_gnt;

  assign idle     = FRAME && IRDY;
  assign any_req  = ~&REQ_n;
  assign sel_gnt  = ~(ONE << sel);
  assign other_req = |(~REQ_n & ~(ONE << gnt_idx));

  // Descending scan so the nearest requester after rr_ptr wins.
  always_comb begin
    sel = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      if (!REQ_n[(int'(rr_ptr) + i) % NUM_MASTERS])
        sel = IDX_W'((int'(rr_ptr) + i) % NUM_MASTERS);
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state     <= IDLE;
      rr_ptr    <= IDX_W'(NUM_MASTERS - 1);
      tmo_cnt   <= '0;
      GNT_n     <= '1;
      gnt_idx   <= '0;
      bus_busy  <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!FRAME) begin
            state    <= BUSY;
            bus_busy <= 1'b1;
          end else if (any_req) begin
            // A parked grant to someone else is dropped for one cycle first.
            if (GNT_n != '1 && GNT_n != sel_gnt) begin
              GNT_n <= '1;
            end else begin
              GNT_n   <= sel_gnt;
              gnt_idx <= sel;
              tmo_cnt <= '0;
              state   <= GRANT;
            end
          end else begin
`ifdef PCI_ARB_PARK_EN
            GNT_n   <= ~(ONE << rr_ptr);
            gnt_idx <= rr_ptr;
`else
            GNT_n   <= '1;
`endif
          end
        end
        GRANT: begin
          if (!FRAME) begin
            state    <= BUSY;
            bus_busy <= 1'b1;
          end else if (REQ_n[gnt_idx]) begin
            GNT_n  <= '1;
            rr_ptr <= gnt_idx;
            state  <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            GNT_n     <= '1;
            timeout_o <= 1'b1;
            rr_ptr    <= gnt_idx;
            state     <= IDLE;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        BUSY: begin
          if (idle) begin
            bus_busy <= 1'b0;
            rr_ptr   <= gnt_idx;
            state    <= IDLE;
`ifndef PCI_ARB_PARK_EN
            GNT_n    <= '1;
`endif
          end else if (other_req) begin
            GNT_n <= '1;
          end
        end
        default: begin
          state <= IDLE;
          GNT_n <= '1;
        end
      endcase
    end
  end

endmodule
